// File: rtl/logic_capture_controller_if.sv
// Register bus, trigger-unit configuration and sample-buffer write port of the capture controller.
// master = CPU / sample source side, slave = controller.
interface logic_capture_controller_if #(
  parameter int SAMPLE_WIDTH   = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int REG_ADDR_WIDTH = 4
);
  logic [REG_ADDR_WIDTH-1:0] regAddr;
  logic [31:0]               regWrData;
  logic                      regWrEn;
  logic [31:0]               regRdData;
  logic                      sampleValid;
  logic                      triggerDetected;
  logic [SAMPLE_WIDTH-1:0]   activeChannels;
  logic [7:0]                edgeChannel;
  logic                      edgeType;
  logic                      edgeTriggerEnabled;
  logic [SAMPLE_WIDTH-1:0]   desiredPattern;
  logic [SAMPLE_WIDTH-1:0]   dontCareChannels;
  logic                      patternTriggerEnabled;
  logic                      bufWrEn;
  logic [ADDR_WIDTH-1:0]     bufWrAddr;
  logic                      captureDone;

  modport master (
    output regAddr, regWrData, regWrEn, sampleValid, triggerDetected,
    input  regRdData, activeChannels, edgeChannel, edgeType, edgeTriggerEnabled,
           desiredPattern, dontCareChannels, patternTriggerEnabled,
           bufWrEn, bufWrAddr, captureDone
  );

  modport slave (
    input  regAddr, regWrData, regWrEn, sampleValid, triggerDetected,
    output regRdData, activeChannels, edgeChannel, edgeType, edgeTriggerEnabled,
           desiredPattern, dontCareChannels, patternTriggerEnabled,
           bufWrEn, bufWrAddr, captureDone
  );
endinterface

// File: rtl/logic_capture_controller.sv
// Capture controller: CPU register file, trigger configuration and capture sequencer
// writing into a circular sample buffer of depth 2**ADDR_WIDTH.
//   state   | meaning
//   IDLE    | no capture running
//   PREFILL | filling PRE_COUNT pre-trigger samples, trigger ignored
//   ARMED   | circular writes, waiting for a qualified trigger
//   POST    | writing POST_COUNT samples after the trigger sample
//   DONE    | capture complete, captureDone high, no writes
module logic_capture_controller #(
  parameter int SAMPLE_WIDTH   = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int REG_ADDR_WIDTH = 4
) (
  input logic                     clk,
  input logic                     reset,
  logic_capture_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, DONE} state_t;

  localparam logic [REG_ADDR_WIDTH-1:0] A_CONTROL = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] A_ACTIVE  = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] A_EDGE    = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] A_PATTERN = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] A_DONTCARE= REG_ADDR_WIDTH'(4);
  localparam logic [REG_ADDR_WIDTH-1:0] A_PATEN   = REG_ADDR_WIDTH'(5);
  localparam logic [REG_ADDR_WIDTH-1:0] A_PRE     = REG_ADDR_WIDTH'(6);
  localparam logic [REG_ADDR_WIDTH-1:0] A_POST    = REG_ADDR_WIDTH'(7);
  localparam logic [REG_ADDR_WIDTH-1:0] A_STATUS  = REG_ADDR_WIDTH'(8);
  localparam logic [REG_ADDR_WIDTH-1:0] A_TRIG    = REG_ADDR_WIDTH'(9);

  state_t                  state;
  logic [SAMPLE_WIDTH-1:0] activeReg, patternReg, dontCareReg;
  logic [9:0]              edgeReg;
  logic                    patternEnReg;
  logic [ADDR_WIDTH-1:0]   preCountReg, postCountReg;
  logic [ADDR_WIDTH-1:0]   preLatched, postLatched, preCnt, postCnt, ptr, trigAddr;
  logic                    aborted, captureDoneReg;
  logic [ADDR_WIDTH:0]     preNext, postNext;
  logic                    ctrlWr, startCmd, abortCmd;
  logic [5:0]              statusBits;

  assign ctrlWr   = bus.regWrEn && (bus.regAddr == A_CONTROL);
  assign startCmd = ctrlWr && bus.regWrData[0];
  assign abortCmd = ctrlWr && bus.regWrData[1];

  // One extra bit so a count of 2**ADDR_WIDTH-1 compares without wrapping.
  assign preNext  = {1'b0, preCnt}  + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign postNext = {1'b0, postCnt} + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      activeReg    <= '0;
      edgeReg      <= '0;
      patternReg   <= '0;
      dontCareReg  <= '0;
      patternEnReg <= 1'b0;
      preCountReg  <= '0;
      postCountReg <= '0;
    end else if (bus.regWrEn) begin
      case (bus.regAddr)
        A_ACTIVE:   activeReg    <= bus.regWrData[SAMPLE_WIDTH-1:0];
        A_EDGE:     edgeReg      <= bus.regWrData[9:0];
        A_PATTERN:  patternReg   <= bus.regWrData[SAMPLE_WIDTH-1:0];
        A_DONTCARE: dontCareReg  <= bus.regWrData[SAMPLE_WIDTH-1:0];
        A_PATEN:    patternEnReg <= bus.regWrData[0];
        A_PRE:      preCountReg  <= bus.regWrData[ADDR_WIDTH-1:0];
        A_POST:     postCountReg <= bus.regWrData[ADDR_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      preLatched     <= '0;
      postLatched    <= '0;
      preCnt         <= '0;
      postCnt        <= '0;
      ptr            <= '0;
      trigAddr       <= '0;
      aborted        <= 1'b0;
      captureDoneReg <= 1'b0;
    end else if (abortCmd && state != IDLE) begin
      state          <= IDLE;
      aborted        <= 1'b1;
      captureDoneReg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Start together with abort in IDLE: abort wins and is a no-op there.
          if (startCmd && !abortCmd) begin
            ptr            <= '0;
            preCnt         <= '0;
            aborted        <= 1'b0;
            captureDoneReg <= 1'b0;
            preLatched     <= preCountReg;
            postLatched    <= postCountReg;
            state          <= (preCountReg == '0) ? ARMED : PREFILL;
          end
        end
        PREFILL: begin
          if (bus.sampleValid) begin
            ptr    <= ptr + ADDR_WIDTH'(1);
            preCnt <= preCnt + ADDR_WIDTH'(1);
            if (preNext == {1'b0, preLatched}) state <= ARMED;
          end
        end
        ARMED: begin
          if (bus.sampleValid) begin
            ptr <= ptr + ADDR_WIDTH'(1);
            if (bus.triggerDetected) begin
              trigAddr <= ptr;
              postCnt  <= '0;
              if (postLatched == '0) begin
                state          <= DONE;
                captureDoneReg <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
        end
        POST: begin
          if (bus.sampleValid) begin
            ptr     <= ptr + ADDR_WIDTH'(1);
            postCnt <= postCnt + ADDR_WIDTH'(1);
            if (postNext == {1'b0, postLatched}) begin
              state          <= DONE;
              captureDoneReg <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign statusBits = {aborted, state == DONE, state == POST, state == ARMED,
                       state == PREFILL, state == IDLE};

  always_comb begin
    bus.regRdData = '0;
    case (bus.regAddr)
      A_ACTIVE:   bus.regRdData[SAMPLE_WIDTH-1:0] = activeReg;
      A_EDGE:     bus.regRdData[9:0]              = edgeReg;
      A_PATTERN:  bus.regRdData[SAMPLE_WIDTH-1:0] = patternReg;
      A_DONTCARE: bus.regRdData[SAMPLE_WIDTH-1:0] = dontCareReg;
      A_PATEN:    bus.regRdData[0]                = patternEnReg;
      A_PRE:      bus.regRdData[ADDR_WIDTH-1:0]   = preCountReg;
      A_POST:     bus.regRdData[ADDR_WIDTH-1:0]   = postCountReg;
      A_STATUS:   bus.regRdData[5:0]              = statusBits;
      A_TRIG:     bus.regRdData[ADDR_WIDTH-1:0]   = trigAddr;
      default: ;
    endcase
  end

  assign bus.activeChannels        = activeReg;
  assign bus.edgeChannel           = edgeReg[7:0];
  assign bus.edgeType              = edgeReg[8];
  assign bus.edgeTriggerEnabled    = edgeReg[9];
  assign bus.desiredPattern        = patternReg;
  assign bus.dontCareChannels      = dontCareReg;
  assign bus.patternTriggerEnabled = patternEnReg;
  assign bus.bufWrEn     = bus.sampleValid && (state == PREFILL || state == ARMED || state == POST);
  assign bus.bufWrAddr   = ptr;
  assign bus.captureDone = captureDoneReg;

endmodule

// File: tb/tb_logic_capture_controller.sv
// Bench for logic_capture_controller: directed scenarios plus randomized captures checked
// against a sample-index model (sample k lands at k mod depth; trigger = first k >= PRE).
module tb_logic_capture_controller;
  localparam int SW = 8;
  localparam int AW = 4;
  localparam int RW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;

  int mPre, mPost, mN, mTrig, dutWrites;
  bit mRun = 1'b0;
  bit mAbort = 1'b0;

  logic_capture_controller_if #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) bus ();

  logic_capture_controller #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mDone();
    return mRun && mTrig >= 0 && mN >= mTrig + 1 + mPost;
  endfunction

  function automatic int mStatus();
    if (!mRun) return mAbort ? 'h21 : 'h01;
    if (mDone()) return 'h10;
    if (mN < mPre) return 'h02;
    if (mTrig < 0) return 'h04;
    return 'h08;
  endfunction

  task automatic regWrite(input int a, input logic [31:0] d);
    bus.sampleValid = 1'b0;
    bus.triggerDetected = 1'b0;
    bus.regAddr = RW'(a);
    bus.regWrData = d;
    bus.regWrEn = 1'b1;
    @(posedge clk); #1;
    bus.regWrEn = 1'b0;
  endtask

  task automatic readCheck(input string tag, input int a, input logic [31:0] exp);
    bus.regWrEn = 1'b0;
    bus.regAddr = RW'(a);
    #1;
    check(tag, bus.regRdData, exp);
  endtask

  task automatic startRun(input int pre, input int post);
    regWrite(6, pre);
    regWrite(7, post);
    regWrite(0, 32'h1);
    mPre = pre; mPost = post; mN = 0; mTrig = -1;
    mRun = 1'b1; mAbort = 1'b0; dutWrites = 0;
  endtask

  task automatic modelAbort();
    if (mRun) begin
      mRun = 1'b0;
      mAbort = 1'b1;
    end
  endtask

  task automatic step(input bit v, input bit t);
    bit expW;
    bus.sampleValid = v;
    bus.triggerDetected = t;
    bus.regAddr = RW'(8);
    bus.regWrEn = 1'b0;
    @(negedge clk);
    expW = mRun && !mDone() && v;
    check("bufWrEn", bus.bufWrEn, expW);
    if (expW) check("bufWrAddr", bus.bufWrAddr, mN % DEPTH);
    check("status", bus.regRdData, mStatus());
    check("captureDone", bus.captureDone, mDone());
    if (bus.bufWrEn) dutWrites++;
    if (expW) begin
      if (t && mTrig < 0 && mN >= mPre) mTrig = mN;
      mN++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.regAddr = '0;
    bus.regWrData = '0;
    bus.regWrEn = 1'b0;
    bus.sampleValid = 1'b0;
    bus.triggerDetected = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // reset state
    readCheck("rst_status", 8, 32'h01);
    readCheck("rst_trigaddr", 9, 32'h0);
    check("rst_bufWrEn", bus.bufWrEn, 1'b0);
    check("rst_captureDone", bus.captureDone, 1'b0);
    check("rst_active", bus.activeChannels, 8'h0);

    // register file
    regWrite(1, 32'hFFFF_FFA5);
    check("activeChannels", bus.activeChannels, 8'hA5);
    readCheck("rd_active", 1, 32'hA5);
    regWrite(2, 32'h0000_0F3C);
    check("edgeChannel", bus.edgeChannel, 8'h3C);
    check("edgeType", bus.edgeType, 1'b1);
    check("edgeTriggerEnabled", bus.edgeTriggerEnabled, 1'b1);
    readCheck("rd_edge", 2, 32'h33C);
    regWrite(3, 32'h5A);
    check("desiredPattern", bus.desiredPattern, 8'h5A);
    regWrite(4, 32'hC3);
    check("dontCareChannels", bus.dontCareChannels, 8'hC3);
    regWrite(5, 32'hFFFF_FFFF);
    check("patternTriggerEnabled", bus.patternTriggerEnabled, 1'b1);
    readCheck("rd_paten", 5, 32'h1);
    regWrite(6, 32'hFFFF_FFF7);
    readCheck("rd_pre", 6, 32'h7);
    regWrite(12, 32'hDEAD);
    readCheck("rd_unmapped", 12, 32'h0);
    regWrite(8, 32'hFF);
    readCheck("rd_status_ro", 8, 32'h01);
    regWrite(9, 32'hF);
    readCheck("rd_trig_ro", 9, 32'h0);
    readCheck("rd_control", 0, 32'h0);

    // PRE=3 POST=2, trigger on sample 5
    startRun(3, 2);
    for (int i = 0; i < 8; i++) step(1'b1, i == 5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("basic_writes", dutWrites, 8);
    check("basic_done", bus.captureDone, 1'b1);
    readCheck("basic_trig", 9, 32'd5);

    // PRE=0 POST=0, trigger on first sample
    startRun(0, 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("zero_writes", dutWrites, 1);
    readCheck("zero_trig", 9, 32'd0);

    // trigger held during PREFILL is ignored
    startRun(4, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    readCheck("prefill_trig", 9, 32'd5);

    // pointer wrap
    startRun(2, 3);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    readCheck("wrap_trig", 9, 32'd4);

    // start+abort together while ARMED
    startRun(1, 5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    regWrite(0, 32'h3);
    modelAbort();
    readCheck("abort_status", 8, 32'h21);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // async reset mid-POST
    startRun(0, 6);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    bus.sampleValid = 1'b1;
    bus.regAddr = RW'(8);
    reset = 1'b0;
    #1;
    check("midrst_status", bus.regRdData, 32'h01);
    check("midrst_bufWrEn", bus.bufWrEn, 1'b0);
    check("midrst_captureDone", bus.captureDone, 1'b0);
    check("midrst_bufWrAddr", bus.bufWrAddr, 4'd0);
    check("midrst_active", bus.activeChannels, 8'h0);
    mRun = 1'b0; mAbort = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 1'b1);

    // randomized captures
    for (int r = 0; r < 30; r++) begin
      int cyc;
      int abortAt;
      startRun($urandom_range(0, 15), $urandom_range(0, 15));
      abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      cyc = 0;
      while (mRun && !mDone() && cyc < 400) begin
        if (cyc == abortAt) begin
          regWrite(0, $urandom_range(2, 3));
          modelAbort();
        end else if ($urandom_range(0, 15) == 0) begin
          regWrite($urandom_range(6, 7), $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          regWrite(0, 32'h1);
        end else begin
          step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        end
        cyc++;
      end
      if (mRun) begin
        check("rand_done", bus.captureDone, 1'b1);
        readCheck("rand_trig", 9, mTrig % DEPTH);
        step(1'b1, 1'b1);
      end else begin
        readCheck("rand_abort_status", 8, 32'h21);
        step(1'b1, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
